// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, ALU op classes
// and R-type funct values.
package cpu_pkg;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b011,
      ALU_MUL = 3'b100
   } alu_ctrl_e;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_MUL = 6'b011000;

endpackage

// File: rtl/alu_control.sv
// ALU control decode: maps the op class and R-type funct field to an ALU code.
module alu_control
   import cpu_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_ctrl_o
);

   alu_ctrl_e ctrl;

   always_comb begin
      ctrl = ALU_ADD;
      case (aluop_i)
         ALUOP_ADD: ctrl = ALU_ADD;
         ALUOP_SUB: ctrl = ALU_SUB;
         ALUOP_OR:  ctrl = ALU_OR;
         default: begin
            // unknown funct codes fall back to add
            case (funct_i)
               FUNCT_AND: ctrl = ALU_AND;
               FUNCT_OR:  ctrl = ALU_OR;
               FUNCT_ADD: ctrl = ALU_ADD;
               FUNCT_SUB: ctrl = ALU_SUB;
               FUNCT_MUL: ctrl = ALU_MUL;
               default:   ctrl = ALU_ADD;
            endcase
         end
      endcase
   end

   assign alu_ctrl_o = ctrl;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB,
// load-use hazard detection and ALU control decode.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              id_valid_i,
   input  logic [DATA_W-1:0] id_rs_data_i,
   input  logic [DATA_W-1:0] id_rt_data_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_alusrc_i,
   input  logic              id_regdst_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              id_memwrite_i,
   input  logic              id_memtoreg_i,
   input  logic [1:0]        id_aluop_i,
   input  logic [5:0]        id_funct_i,
   input  logic              exm_regwrite_i,
   input  logic [REG_AW-1:0] exm_rd_i,
   input  logic [DATA_W-1:0] exm_data_i,
   input  logic              wb_regwrite_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic [DATA_W-1:0] wb_data_i,
   output logic [DATA_W-1:0] data1_o,
   output logic [DATA_W-1:0] data2_o,
   output logic [2:0]        alu_ctrl_o,
   output logic [DATA_W-1:0] store_data_o,
   output logic [REG_AW-1:0] wr_reg_o,
   output logic              valid_o,
   output logic              regwrite_o,
   output logic              memread_o,
   output logic              memwrite_o,
   output logic              memtoreg_o,
   output logic              load_use_o
);

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic              memread;
      logic              memwrite;
      logic              memtoreg;
      logic              alusrc;
      logic              regdst;
      logic [1:0]        aluop;
      logic [5:0]        funct;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
   } ex_reg_t;

   ex_reg_t ex_d, ex_q;

   function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] r,
                                             input logic [DATA_W-1:0] reg_val);
      logic [DATA_W-1:0] v;
      v = reg_val;
      if (r != '0 && exm_regwrite_i && exm_rd_i == r)
         v = exm_data_i;
      else if (r != '0 && wb_regwrite_i && wb_rd_i == r)
         v = wb_data_i;
      return v;
   endfunction

   always_comb begin
      load_use_o = ex_q.valid && ex_q.memread && id_valid_i && (ex_q.rt != '0) &&
                   ((ex_q.rt == id_rs_i) || (ex_q.rt == id_rt_i));
   end

   // a bubble clears the whole slot so it can never raise a hazard itself
   always_comb begin
      ex_d = ex_q;
      if (flush_i || load_use_o) begin
         ex_d = '0;
      end else if (!stall_i) begin
         ex_d.valid    = id_valid_i;
         ex_d.regwrite = id_regwrite_i;
         ex_d.memread  = id_memread_i;
         ex_d.memwrite = id_memwrite_i;
         ex_d.memtoreg = id_memtoreg_i;
         ex_d.alusrc   = id_alusrc_i;
         ex_d.regdst   = id_regdst_i;
         ex_d.aluop    = id_aluop_i;
         ex_d.funct    = id_funct_i;
         ex_d.rs       = id_rs_i;
         ex_d.rt       = id_rt_i;
         ex_d.rd       = id_rd_i;
         ex_d.rs_data  = id_rs_data_i;
         ex_d.rt_data  = id_rt_data_i;
         ex_d.imm      = id_imm_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) ex_q <= '0;
      else       ex_q <= ex_d;
   end

   always_comb begin
      data1_o      = fwd(ex_q.rs, ex_q.rs_data);
      store_data_o = fwd(ex_q.rt, ex_q.rt_data);
      data2_o      = ex_q.alusrc ? ex_q.imm : store_data_o;
      wr_reg_o     = ex_q.regdst ? ex_q.rd : ex_q.rt;
   end

   assign valid_o    = ex_q.valid;
   assign regwrite_o = ex_q.regwrite;
   assign memread_o  = ex_q.memread;
   assign memwrite_o = ex_q.memwrite;
   assign memtoreg_o = ex_q.memtoreg;

   alu_control u_alu_control (
      .aluop_i    (ex_q.aluop),
      .funct_i    (ex_q.funct),
      .alu_ctrl_o (alu_ctrl_o)
   );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random checks of id_ex_stage against a slot-level reference model.
module tb_id_ex_stage;

   logic        clk_i = 1'b0;
   logic        rst_i, stall_i, flush_i, id_valid_i;
   logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
   logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
   logic        id_alusrc_i, id_regdst_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i;
   logic [1:0]  id_aluop_i;
   logic [5:0]  id_funct_i;
   logic        exm_regwrite_i, wb_regwrite_i;
   logic [4:0]  exm_rd_i, wb_rd_i;
   logic [31:0] exm_data_i, wb_data_i;
   logic [31:0] data1_o, data2_o, store_data_o;
   logic [2:0]  alu_ctrl_o;
   logic [4:0]  wr_reg_o;
   logic        valid_o, regwrite_o, memread_o, memwrite_o, memtoreg_o, load_use_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   id_ex_stage dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .id_valid_i(id_valid_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
      .id_imm_i(id_imm_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
      .id_alusrc_i(id_alusrc_i), .id_regdst_i(id_regdst_i), .id_regwrite_i(id_regwrite_i),
      .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i),
      .id_aluop_i(id_aluop_i), .id_funct_i(id_funct_i),
      .exm_regwrite_i(exm_regwrite_i), .exm_rd_i(exm_rd_i), .exm_data_i(exm_data_i),
      .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .data1_o(data1_o), .data2_o(data2_o), .alu_ctrl_o(alu_ctrl_o),
      .store_data_o(store_data_o), .wr_reg_o(wr_reg_o), .valid_o(valid_o),
      .regwrite_o(regwrite_o), .memread_o(memread_o), .memwrite_o(memwrite_o),
      .memtoreg_o(memtoreg_o), .load_use_o(load_use_o)
   );

   // What the EX slot currently holds, as an instruction record.
   typedef struct {
      bit       valid, regwrite, memread, memwrite, memtoreg, alusrc, regdst;
      bit [1:0] aluop;
      bit [5:0] funct;
      int       rs, rt, rd;
      bit [31:0] rs_data, rt_data, imm;
   } slot_t;

   slot_t m;

   function automatic slot_t empty_slot();
      slot_t s;
      s.valid = 0; s.regwrite = 0; s.memread = 0; s.memwrite = 0; s.memtoreg = 0;
      s.alusrc = 0; s.regdst = 0; s.aluop = 0; s.funct = 0;
      s.rs = 0; s.rt = 0; s.rd = 0; s.rs_data = 0; s.rt_data = 0; s.imm = 0;
      return s;
   endfunction

   function automatic bit exp_load_use();
      return m.valid && m.memread && id_valid_i && m.rt != 0 &&
             (m.rt == int'(id_rs_i) || m.rt == int'(id_rt_i));
   endfunction

   function automatic bit [31:0] newest_value(int r, bit [31:0] held);
      if (r == 0) return held;
      if (exm_regwrite_i && int'(exm_rd_i) == r) return exm_data_i;
      if (wb_regwrite_i && int'(wb_rd_i) == r) return wb_data_i;
      return held;
   endfunction

   function automatic bit [2:0] ref_alu(bit [1:0] op, bit [5:0] f);
      if (op == 2'd0) return 3'd2;
      if (op == 2'd1) return 3'd3;
      if (op == 2'd3) return 3'd1;
      if (f == 6'd36) return 3'd0;
      if (f == 6'd37) return 3'd1;
      if (f == 6'd32) return 3'd2;
      if (f == 6'd34) return 3'd3;
      if (f == 6'd24) return 3'd4;
      return 3'd2;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      bit [31:0] st;
      st = newest_value(m.rt, m.rt_data);
      chk({tag, ".data1"}, data1_o, newest_value(m.rs, m.rs_data));
      chk({tag, ".store"}, store_data_o, st);
      chk({tag, ".data2"}, data2_o, m.alusrc ? m.imm : st);
      chk({tag, ".alu"}, 32'(alu_ctrl_o), 32'(ref_alu(m.aluop, m.funct)));
      chk({tag, ".wr_reg"}, 32'(wr_reg_o), m.regdst ? m.rd : m.rt);
      chk({tag, ".ctrl"}, {27'd0, valid_o, regwrite_o, memread_o, memwrite_o, memtoreg_o},
          {27'd0, m.valid, m.regwrite, m.memread, m.memwrite, m.memtoreg});
      chk({tag, ".load_use"}, 32'(load_use_o), 32'(exp_load_use()));
   endtask

   task automatic step(string tag);
      slot_t nxt;
      nxt = m;
      if (rst_i || flush_i || exp_load_use()) nxt = empty_slot();
      else if (!stall_i) begin
         nxt.valid = id_valid_i; nxt.regwrite = id_regwrite_i; nxt.memread = id_memread_i;
         nxt.memwrite = id_memwrite_i; nxt.memtoreg = id_memtoreg_i; nxt.alusrc = id_alusrc_i;
         nxt.regdst = id_regdst_i; nxt.aluop = id_aluop_i; nxt.funct = id_funct_i;
         nxt.rs = id_rs_i; nxt.rt = id_rt_i; nxt.rd = id_rd_i;
         nxt.rs_data = id_rs_data_i; nxt.rt_data = id_rt_data_i; nxt.imm = id_imm_i;
      end
      @(posedge clk_i);
      m = nxt;
      #1;
      check_all(tag);
   endtask

   task automatic id_clear();
      id_valid_i = 0; id_rs_data_i = 0; id_rt_data_i = 0; id_imm_i = 0;
      id_rs_i = 0; id_rt_i = 0; id_rd_i = 0;
      id_alusrc_i = 0; id_regdst_i = 0; id_regwrite_i = 0; id_memread_i = 0;
      id_memwrite_i = 0; id_memtoreg_i = 0; id_aluop_i = 0; id_funct_i = 0;
   endtask

   task automatic fwd_clear();
      exm_regwrite_i = 0; exm_rd_i = 0; exm_data_i = 0;
      wb_regwrite_i = 0; wb_rd_i = 0; wb_data_i = 0;
   endtask

   initial begin
      m = empty_slot();
      rst_i = 1; stall_i = 0; flush_i = 0;
      id_clear(); fwd_clear();
      #2;

      // reset values
      step("reset");
      chk("reset.data1_const", data1_o, 32'h0);
      chk("reset.data2_const", data2_o, 32'h0);
      chk("reset.alu_const", 32'(alu_ctrl_o), 32'd2);
      chk("reset.valid_const", 32'(valid_o), 32'd0);
      chk("reset.lu_const", 32'(load_use_o), 32'd0);
      rst_i = 0;

      // R-type add, no hazards
      id_valid_i = 1; id_rs_i = 1; id_rs_data_i = 5; id_rt_i = 2; id_rt_data_i = 7;
      id_rd_i = 9; id_regdst_i = 1; id_regwrite_i = 1; id_aluop_i = 2'b10; id_funct_i = 6'b100000;
      step("radd");
      chk("radd.data1_const", data1_o, 32'd5);
      chk("radd.data2_const", data2_o, 32'd7);
      chk("radd.alu_const", 32'(alu_ctrl_o), 32'd2);
      chk("radd.wr_const", 32'(wr_reg_o), 32'd9);

      // double forward: EX/MEM wins over MEM/WB
      id_rs_i = 3; id_rs_data_i = 32'h99;
      step("dfwd_load");
      exm_regwrite_i = 1; exm_rd_i = 3; exm_data_i = 32'h10;
      wb_regwrite_i = 1; wb_rd_i = 3; wb_data_i = 32'h20;
      #1;
      chk("dfwd.data1_const", data1_o, 32'h10);
      check_all("dfwd");
      // register 0 never forwards
      id_rs_i = 0; id_rs_data_i = 32'h55; exm_rd_i = 0; wb_rd_i = 0;
      step("r0");
      chk("r0.data1_const", data1_o, 32'h55);
      fwd_clear();

      // load-use
      id_clear();
      id_valid_i = 1; id_memread_i = 1; id_regwrite_i = 1; id_memtoreg_i = 1;
      id_rt_i = 4; id_rs_i = 1; id_alusrc_i = 1; id_imm_i = 8;
      step("lw");
      id_clear();
      id_valid_i = 1; id_rs_i = 4; id_rt_i = 5; id_memwrite_i = 1; id_alusrc_i = 1;
      #1;
      chk("lu.flag_const", 32'(load_use_o), 32'd1);
      step("lu_bubble");
      chk("lu.valid_const", 32'(valid_o), 32'd0);
      chk("lu.memwrite_const", 32'(memwrite_o), 32'd0);

      // stall holds, forwarding still tracks writebacks
      id_clear();
      id_valid_i = 1; id_rs_i = 6; id_rs_data_i = 32'h66; id_rt_i = 7; id_rt_data_i = 32'h70;
      step("pre_stall");
      stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         id_rs_i = 5'($urandom_range(1, 31)); id_rs_data_i = $urandom;
         id_valid_i = 0;
         step("stall");
         chk("stall.hold_const", data1_o, 32'h66);
      end
      wb_regwrite_i = 1; wb_rd_i = 6; wb_data_i = 32'h77;
      #1;
      chk("stall.wb_const", data1_o, 32'h77);
      check_all("stall_wb");
      fwd_clear();

      // flush beats stall
      flush_i = 1;
      step("flush");
      chk("flush.valid_const", 32'(valid_o), 32'd0);
      flush_i = 0; stall_i = 0;
      id_clear();
      id_valid_i = 1; id_regwrite_i = 1; id_rs_i = 2; id_rs_data_i = 32'h1234; id_aluop_i = 2'b01;
      step("refill");
      // reset mid-stream while stalled
      stall_i = 1; rst_i = 1;
      step("rst_mid");
      chk("rst_mid.data1_const", data1_o, 32'h0);
      chk("rst_mid.alu_const", 32'(alu_ctrl_o), 32'd2);
      chk("rst_mid.valid_const", 32'(valid_o), 32'd0);
      rst_i = 0; stall_i = 0;

      // addi with all-ones immediate, then multiply decode
      id_clear();
      id_valid_i = 1; id_alusrc_i = 1; id_imm_i = 32'hFFFF_FFFF; id_aluop_i = 2'b00; id_rt_i = 8;
      step("addi");
      chk("addi.data2_const", data2_o, 32'hFFFF_FFFF);
      chk("addi.alu_const", 32'(alu_ctrl_o), 32'd2);
      id_alusrc_i = 0; id_aluop_i = 2'b10; id_funct_i = 6'b011000;
      step("mul");
      chk("mul.alu_const", 32'(alu_ctrl_o), 32'd4);

      // random traffic on a small register window so hazards and forwards occur
      for (int i = 0; i < 400; i++) begin
         rst_i   = ($urandom_range(0, 49) == 0);
         flush_i = ($urandom_range(0, 11) == 0);
         stall_i = ($urandom_range(0, 4) == 0);
         id_valid_i = $urandom_range(0, 3) != 0;
         id_rs_i = 5'($urandom_range(0, 7)); id_rt_i = 5'($urandom_range(0, 7));
         id_rd_i = 5'($urandom_range(0, 31));
         id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = $urandom;
         {id_alusrc_i, id_regdst_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i} =
            6'($urandom);
         id_aluop_i = 2'($urandom);
         case ($urandom_range(0, 5))
            0: id_funct_i = 6'b100100;
            1: id_funct_i = 6'b100101;
            2: id_funct_i = 6'b100000;
            3: id_funct_i = 6'b100010;
            4: id_funct_i = 6'b011000;
            default: id_funct_i = 6'($urandom);
         endcase
         exm_regwrite_i = 1'($urandom); exm_rd_i = 5'($urandom_range(0, 7)); exm_data_i = $urandom;
         wb_regwrite_i = 1'($urandom); wb_rd_i = 5'($urandom_range(0, 7)); wb_data_i = $urandom;
         #1;
         chk("rand.pre_lu", 32'(load_use_o), 32'(exp_load_use()));
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
